// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the banked
// register file.
package regfile_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_NUM_BANKS = 2;
    localparam int DEF_LINK_REG  = 31;
    localparam int DEF_SAVE_REG  = 27;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        CLEAR = 2'd2
    } clr_state_e;

endpackage

// File: rtl/bank_clear_fsm.sv
// Sequential bank-clear engine: walks every index of one bank (CLEAR)
// or of all banks (INIT after reset), emitting a bank mask and index.
module bank_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int NUM_BANKS = DEF_NUM_BANKS,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear_req,
    input  logic [BANK_W-1:0]    i_clear_bank,
    output logic                 o_busy,
    output logic [NUM_BANKS-1:0] o_clr_mask,
    output logic [ADDR_W-1:0]    o_clr_idx
);

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [BANK_W-1:0] r_tgt;
    logic [BANK_W-1:0] w_tgt_nxt;

    // State, index and target registers; reset restarts INIT at idx 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= INIT;
            r_idx   <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Next state: arm from IDLE, walk the index, leave after the last one.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tgt_nxt   = r_tgt;
        unique case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_tgt_nxt   = i_clear_bank;
                    w_idx_nxt   = '0;
                    w_state_nxt = CLEAR;
                end
            end
            INIT, CLEAR: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Banks under clear; reset masks every bank straight away.
    always_comb begin
        o_clr_mask = '0;
        o_busy     = i_reset || (r_state != IDLE);
        o_clr_idx  = r_idx;
        if (i_reset) begin
            o_clr_mask = '1;
        end else begin
            unique case (r_state)
                INIT:    o_clr_mask = '1;
                CLEAR:   o_clr_mask = NUM_BANKS'(1) << r_tgt;
                default: o_clr_mask = '0;
            endcase
        end
    end

endmodule

// File: rtl/banked_reg_file.sv
// Multi-context register file with prioritised write ports, optional
// hard-wired zero register and a sequential bank-clear engine.
module banked_reg_file
    import regfile_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int ADDR_W      = DEF_ADDR_W,
    parameter  int NUM_BANKS   = DEF_NUM_BANKS,
    parameter  int LINK_REG    = DEF_LINK_REG,
    parameter  int SAVE_REG    = DEF_SAVE_REG,
    parameter  int PC_INC      = 1,
    parameter  int ZERO_REG_EN = 1,
    localparam int BANK_W      = $clog2(NUM_BANKS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] end_rd,
    input  logic [ADDR_W-1:0] end_rs,
    input  logic [ADDR_W-1:0] end_rt,
    input  logic [BANK_W-1:0] bank_rd,
    input  logic [BANK_W-1:0] bank_rs_rt,
    input  logic              write,
    input  logic [DATA_W-1:0] dados_escrita,
    input  logic              jal,
    input  logic [DATA_W-1:0] pc,
    input  logic              save_pc,
    input  logic [DATA_W-1:0] pc_saved,
    input  logic              clear_req,
    input  logic [BANK_W-1:0] clear_bank,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic              busy
);

    localparam int REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]    r_regs [NUM_BANKS][REGS];
    logic [NUM_BANKS-1:0] w_clr_mask;
    logic [ADDR_W-1:0]    w_clr_idx;
    logic                 w_wr_ok;
    logic [DATA_W-1:0]    w_link;
    logic [DATA_W-1:0]    w_save;

    bank_clear_fsm #(
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_clr (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_clear_req  (clear_req),
        .i_clear_bank (clear_bank),
        .o_busy       (busy),
        .o_clr_mask   (w_clr_mask),
        .o_clr_idx    (w_clr_idx)
    );

    assign w_wr_ok = !w_clr_mask[bank_rd];
    assign w_link  = pc + DATA_W'(PC_INC);
    assign w_save  = pc_saved + DATA_W'(PC_INC);

    // Array update: clear strobe first, then save_pc > jal > write.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < REGS; i++) begin
                if (w_clr_mask[b] && (w_clr_idx == ADDR_W'(i))) begin
                    r_regs[b][i] <= '0;
                end else if (w_wr_ok && (bank_rd == BANK_W'(b)) &&
                             !((ZERO_REG_EN != 0) && (i == 0))) begin
                    if (save_pc && (i == SAVE_REG)) begin
                        r_regs[b][i] <= w_save;
                    end else if (jal && (i == LINK_REG)) begin
                        r_regs[b][i] <= w_link;
                    end else if (write && (end_rd == ADDR_W'(i))) begin
                        r_regs[b][i] <= dados_escrita;
                    end
                end
            end
        end
    end

    // Combinational reads; banks under clear and the zero register read 0.
    always_comb begin
        out1 = r_regs[bank_rs_rt][end_rs];
        out2 = r_regs[bank_rs_rt][end_rt];
        out3 = r_regs[bank_rd][end_rd];
        if (w_clr_mask[bank_rs_rt] ||
            ((ZERO_REG_EN != 0) && (end_rs == '0))) begin
            out1 = '0;
        end
        if (w_clr_mask[bank_rs_rt] ||
            ((ZERO_REG_EN != 0) && (end_rt == '0))) begin
            out2 = '0;
        end
        if (w_clr_mask[bank_rd] ||
            ((ZERO_REG_EN != 0) && (end_rd == '0))) begin
            out3 = '0;
        end
    end

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed and randomised bench for banked_reg_file against a
// whole-bank behavioural model.
module tb_banked_reg_file;

    localparam int NB   = 2;
    localparam int REGS = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  end_rd, end_rs, end_rt;
    logic [0:0]  bank_rd, bank_rs_rt, clear_bank;
    logic        write, jal, save_pc, clear_req;
    logic [31:0] dados_escrita, pc, pc_saved;
    logic [31:0] out1, out2, out3;
    logic        busy;

    logic [31:0] m_regs [NB][REGS];
    int          m_left = REGS;
    bit          m_init = 1'b1;
    int          m_tgt  = 0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_busy   = 0;

    always #5 clock = ~clock;

    banked_reg_file dut (
        .clock         (clock),
        .reset         (reset),
        .end_rd        (end_rd),
        .end_rs        (end_rs),
        .end_rt        (end_rt),
        .bank_rd       (bank_rd),
        .bank_rs_rt    (bank_rs_rt),
        .write         (write),
        .dados_escrita (dados_escrita),
        .jal           (jal),
        .pc            (pc),
        .save_pc       (save_pc),
        .pc_saved      (pc_saved),
        .clear_req     (clear_req),
        .clear_bank    (clear_bank),
        .out1          (out1),
        .out2          (out2),
        .out3          (out3),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_masked(input int b);
        return reset || (m_left > 0 && (m_init || b == m_tgt));
    endfunction

    function automatic logic [31:0] m_read(input int b, input int a);
        if (m_masked(b) || a == 0) return 32'h0;
        return m_regs[b][a];
    endfunction

    task automatic m_zero_bank(input int b);
        for (int i = 0; i < REGS; i++) m_regs[b][i] = 32'h0;
    endtask

    task automatic m_step();
        bit blk;
        if (reset) begin
            for (int b = 0; b < NB; b++) m_zero_bank(b);
            m_left = REGS;
            m_init = 1'b1;
        end else begin
            blk = (m_left > 0) && (m_init || int'(bank_rd) == m_tgt);
            if (!blk) begin
                if (write && end_rd != 0) m_regs[bank_rd][end_rd] = dados_escrita;
                if (jal) m_regs[bank_rd][31] = pc + 32'd1;
                if (save_pc) m_regs[bank_rd][27] = pc_saved + 32'd1;
            end
            if (m_left > 0) begin
                m_left--;
            end else if (clear_req) begin
                m_zero_bank(int'(clear_bank));
                m_left = REGS;
                m_init = 1'b0;
                m_tgt  = int'(clear_bank);
            end
        end
    endtask

    task automatic check_outs();
        #1;
        chk("out1", out1, m_read(int'(bank_rs_rt), int'(end_rs)));
        chk("out2", out2, m_read(int'(bank_rs_rt), int'(end_rt)));
        chk("out3", out3, m_read(int'(bank_rd), int'(end_rd)));
        chk("busy", {31'b0, busy}, {31'b0, (reset || m_left > 0)});
        if (busy === 1'b1) n_busy++;
    endtask

    task automatic cycle();
        check_outs();
        @(posedge clock);
        m_step();
        @(negedge clock);
    endtask

    task automatic idle_in();
        write = 0; jal = 0; save_pc = 0; clear_req = 0;
    endtask

    initial begin
        reset = 1; idle_in();
        end_rd = 0; end_rs = 0; end_rt = 0;
        bank_rd = 0; bank_rs_rt = 0; clear_bank = 0;
        dados_escrita = 0; pc = 0; pc_saved = 0;
        for (int b = 0; b < NB; b++) m_zero_bank(b);

        // reset held
        for (int k = 0; k < 3; k++) cycle();

        // release reset with writes hammering during INIT
        reset = 0; n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            write = 1;
            bank_rd = 1'($urandom_range(0, 1));
            end_rd = 5'($urandom_range(1, 31));
            dados_escrita = $urandom;
            cycle();
        end
        chk("init_busy_len", n_busy, 32);
        idle_in();

        // every register zero after INIT
        for (int a = 0; a < REGS; a++) begin
            bank_rs_rt = 0; end_rs = 5'(a); end_rt = 5'(a);
            bank_rd = 1; end_rd = 5'(a);
            cycle();
        end

        // basic write, visible next cycle, other bank untouched
        bank_rd = 1; end_rd = 5; write = 1; dados_escrita = 32'hDEADBEEF;
        cycle();
        idle_in(); bank_rs_rt = 0; end_rs = 5;
        #1;
        chk("wr_out3", out3, 32'hDEADBEEF);
        chk("wr_out1_b0", out1, 32'h0);
        cycle();

        // simultaneous write/jal/save_pc
        bank_rd = 0; end_rd = 31; write = 1; dados_escrita = 32'h11;
        jal = 1; pc = 32'h40; save_pc = 1; pc_saved = 32'h80;
        cycle();
        idle_in(); bank_rs_rt = 0; end_rs = 31; end_rt = 27;
        #1;
        chk("jal_beats_wr", out1, 32'h41);
        chk("save_pc", out2, 32'h81);
        cycle();

        // zero register and carry wrap
        bank_rd = 0; end_rd = 0; write = 1; dados_escrita = 32'hFFFFFFFF;
        cycle();
        write = 0; jal = 1; pc = 32'hFFFFFFFF;
        cycle();
        idle_in(); end_rs = 0; end_rt = 31;
        #1;
        chk("zero_reg", out1, 32'h0);
        chk("pc_wrap", out2, 32'h0);
        cycle();

        // bank clear with traffic to both banks
        bank_rd = 1; end_rd = 3; write = 1; dados_escrita = 32'h33;
        cycle();
        bank_rd = 0; dados_escrita = 32'h22;
        cycle();
        idle_in(); clear_req = 1; clear_bank = 1;
        bank_rs_rt = 1; end_rs = 3; end_rt = 5;
        cycle();
        clear_req = 0; n_busy = 0;
        for (int k = 0; k < 34; k++) begin
            idle_in();
            bank_rs_rt = 1; end_rs = 3; end_rt = 5;
            if (k == 10) begin
                bank_rd = 0; end_rd = 4; write = 1; dados_escrita = 32'h44;
            end else if (k == 12) begin
                bank_rd = 1; end_rd = 7; write = 1; dados_escrita = 32'h77;
            end else if (k == 14) begin
                clear_req = 1; clear_bank = 0;
            end
            if (k < 32) begin
                #1;
                chk("clr_b1_read", out1, 32'h0);
                #0;
            end
            cycle();
        end
        chk("clear_busy_len", n_busy, 32);
        bank_rs_rt = 0; end_rs = 4; end_rt = 3;
        #1;
        chk("b0_mid_clear_wr", out1, 32'h44);
        chk("b0_kept", out2, 32'h22);
        cycle();
        bank_rs_rt = 1; end_rs = 7; end_rt = 3;
        cycle();

        // random traffic with occasional clears and resets
        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            write = $urandom_range(0, 1);
            jal = ($urandom_range(0, 3) == 0);
            save_pc = ($urandom_range(0, 3) == 0);
            clear_req = ($urandom_range(0, 24) == 0);
            clear_bank = 1'($urandom_range(0, 1));
            bank_rd = 1'($urandom_range(0, 1));
            bank_rs_rt = 1'($urandom_range(0, 1));
            end_rd = 5'($urandom_range(0, 31));
            end_rs = ($urandom_range(0, 1) == 1) ? end_rd : 5'($urandom_range(0, 31));
            end_rt = ($urandom_range(0, 1) == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            dados_escrita = $urandom; pc = $urandom; pc_saved = $urandom;
            cycle();
        end
        reset = 0; idle_in();
        for (int k = 0; k < 34; k++) cycle();

        // reset mid-CLEAR restarts INIT
        bank_rd = 0; end_rd = 9; write = 1; dados_escrita = 32'h99;
        cycle();
        idle_in(); clear_req = 1; clear_bank = 1;
        cycle();
        clear_req = 0;
        for (int k = 0; k < 10; k++) cycle();
        reset = 1;
        cycle(); cycle();
        reset = 0; n_busy = 0;
        for (int k = 0; k < 36; k++) cycle();
        chk("reinit_busy_len", n_busy, 32);
        for (int a = 0; a < REGS; a++) begin
            bank_rs_rt = 0; end_rs = 5'(a);
            bank_rd = 1; end_rd = 5'(a); end_rt = 5'(a);
            #1;
            chk("reinit_zero", out1 | out3, 32'h0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
- Parametrised multi-context register file: NUM_BANKS banks of 2^ADDR_W registers, each DATA_W bits wide.
- Successor to the two-bank (kernel/program) file. It generalises bank count and width, adds a hard-wired zero register, explicit write-port priority, and a sequential bank-clear engine with a busy flag.
- Sits in the decode/writeback stage. Reads are combinational; writes take effect at the rising clock edge.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; each bank holds 2^ADDR_W registers.
- NUM_BANKS, 2, number of contexts; must be a power of two and at least 2. BANK_W = clog2(NUM_BANKS) is a derived localparam.
- LINK_REG, 31, index written by jal.
- SAVE_REG, 27, index written by save_pc.
- PC_INC, 1, increment added to pc and pc_saved before they are stored.
- ZERO_REG_EN, 1, when 1 register 0 of every bank reads 0 and ignores writes.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- end_rd  in  ADDR_W  destination / third-read address.
- end_rs  in  ADDR_W  read address, port 1.
- end_rt  in  ADDR_W  read address, port 2.
- bank_rd  in  BANK_W  bank for writes and out3.
- bank_rs_rt  in  BANK_W  bank for out1 and out2.
- write  in  1  general write enable.
- dados_escrita  in  DATA_W  general write data.
- jal  in  1  link write enable.
- pc  in  DATA_W  link source.
- save_pc  in  1  saved-PC write enable.
- pc_saved  in  DATA_W  saved-PC source.
- clear_req  in  1  single-cycle request to zero one bank.
- clear_bank  in  BANK_W  bank to clear.
- out1  out  DATA_W  reg[bank_rs_rt][end_rs].
- out2  out  DATA_W  reg[bank_rs_rt][end_rt].
- out3  out  DATA_W  reg[bank_rd][end_rd].
- busy  out  1  clear engine active.

Behaviour:
- Clock and reset: single clock domain, clock; reset is synchronous and active-high.
- Writes, all on the rising edge and all into bank bank_rd:
  - write stores dados_escrita at end_rd.
  - jal stores pc+PC_INC at LINK_REG.
  - save_pc stores pc_saved+PC_INC at SAVE_REG.
- Simultaneous writes:
  - Writes to distinct indices all commit in the same cycle.
  - Writes to the same index resolve by priority: save_pc > jal > write.
- Additions are modulo 2^DATA_W; carry is discarded.
- Zero register: with ZERO_REG_EN=1, any write to index 0 is dropped and reads of index 0 return 0.
- Reads:
  - Purely combinational from array state; no write-to-read bypass, so a write becomes visible the cycle after its edge.
  - Any read addressing a bank currently being cleared returns 0.
- Clear engine FSM, states IDLE, INIT, CLEAR; counter idx is ADDR_W bits.
  - While reset=1: state=INIT, idx=0, busy=1, all reads return 0, all writes dropped.
  - INIT: each cycle zeroes register idx in every bank and increments idx. When idx = 2^ADDR_W-1 has been written, go to IDLE. After reset falls this takes 2^ADDR_W cycles, and busy deasserts the following cycle.
  - IDLE: busy=0. clear_req=1 latches clear_bank into tgt, sets idx=0 and moves to CLEAR; busy=1 from the next cycle.
  - CLEAR: each cycle zeroes reg[tgt][idx] and increments idx; after idx = 2^ADDR_W-1, return to IDLE. Duration is 2^ADDR_W cycles.
    - Writes to bank tgt are dropped.
    - Writes to other banks proceed normally.
- Boundaries:
  - clear_req while busy=1 is ignored and not queued.
  - reset asserted mid-CLEAR aborts the clear and restarts INIT at idx=0.
  - idx wraps only on the FSM exit; it is never reused without a re-arm.
- Reset values: busy=1. out1/out2/out3 read 0 while reset is high and during INIT.

Decomposition:
- Shared package regfile_pkg:
  - Default DATA_W, ADDR_W, NUM_BANKS, LINK_REG, SAVE_REG.
  - FSM state enum (IDLE, INIT, CLEAR).
- Sub-module: bank_clear_fsm, which owns state, idx, tgt and busy, and emits per-bank clear strobes plus the clear index.
- The array and write-priority logic stay in banked_reg_file.

Test Plan:
- Release reset, hold write=1 for 40 cycles -> busy=1 for exactly 32 cycles after reset falls; writes during that window are dropped and every register reads 0 once busy=0.
- bank_rd=1, end_rd=5, write=1, dados_escrita=0xDEADBEEF -> next cycle out3=0xDEADBEEF with bank_rd=1; with bank_rs_rt=0, end_rs=5 -> out1=0.
- write to end_rd=31 with data 0x11, jal=1, pc=0x40, save_pc=1, pc_saved=0x80, same cycle -> reg[31]=0x41 (jal beats write), reg[27]=0x81.
- write end_rd=0, data 0xFFFFFFFF -> out1 with end_rs=0 stays 0; jal with pc=0xFFFFFFFF -> reg[31]=0.
- Fill bank 1 reg 3 = 0x33 and bank 0 reg 3 = 0x22, then clear_req with clear_bank=1 -> busy=1 for 32 cycles and bank-1 reads return 0 throughout. Bank-0 write to reg 4 = 0x44 mid-clear -> out1 (bank 0, reg 4) = 0x44. Bank-1 write mid-clear is dropped; afterwards bank 0 reg 3 still reads 0x22.
- Assert reset at cycle 10 of a CLEAR -> INIT restarts at idx=0, busy=1 for 32 cycles after reset falls, all banks zero.
